// File: rtl/eeprom_pkg.sv
// Shared constants, state encoding and helpers for the EEPROM engine scheduler.
// Slot counts are expressed in engine bit slots of TICK_DIV clock cycles each.
package eeprom_pkg;

  localparam logic [7:0] EE_WRITE = 8'hA0;
  localparam logic [7:0] EE_READ  = 8'hA1;
  localparam logic [7:0] EE_IDLE  = 8'h00;

  localparam int unsigned DEF_TICK_DIV  = 1024;
  localparam int unsigned DEF_WR_SLOTS  = 34;
  localparam int unsigned DEF_RD_SLOTS  = 44;
  localparam int unsigned DEF_TWR_SLOTS = 245;

  localparam int unsigned SLOT_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_TWR     = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic logic [7:0] ctrlByte(input logic isWrite);
    return isWrite ? EE_WRITE : EE_READ;
  endfunction

endpackage

// File: rtl/eeprom_slot_timer.sv
// Tick + slot counter that measures a window of slots_i * TICK_DIV cycles.
// A start pulse arms it; expire_o is high in the last cycle of the window.
module eeprom_slot_timer
  import eeprom_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [SLOT_W-1:0] slots_i,
  output logic              expire_o
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]     tick_q, tick_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOT_W-1:0] target_q, target_d;
  logic              active_q, active_d;
  logic              tickWrap;

  assign tickWrap = active_q && (tick_q == TICK_LAST);
  assign expire_o = tickWrap && ((slot_q + SLOT_W'(1)) == target_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tick_q   <= '0;
      slot_q   <= '0;
      target_q <= '0;
      active_q <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      slot_q   <= slot_d;
      target_q <= target_d;
      active_q <= active_d;
    end
  end

  // A start in the expiring cycle wins so RUN can hand straight over to TWR.
  always_comb begin
    tick_d   = tick_q;
    slot_d   = slot_q;
    target_d = target_q;
    active_d = active_q;
    if (start_i) begin
      tick_d   = '0;
      slot_d   = '0;
      target_d = slots_i;
      active_d = 1'b1;
    end else if (expire_o) begin
      tick_d   = '0;
      slot_d   = '0;
      active_d = 1'b0;
    end else if (active_q) begin
      if (tickWrap) begin
        tick_d = '0;
        slot_d = slot_q + SLOT_W'(1);
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

endmodule

// File: rtl/eeprom_sched.sv
// Round-robin scheduler sharing one I2C EEPROM engine between two requesters.
// Engine completion is inferred by counting bit slots since the engine has no done flag.
module eeprom_sched
  import eeprom_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned WR_SLOTS  = DEF_WR_SLOTS,
  parameter int unsigned RD_SLOTS  = DEF_RD_SLOTS,
  parameter int unsigned TWR_SLOTS = DEF_TWR_SLOTS
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  req_we_i,
  input  logic [7:0]  req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [7:0]  rdata_o,
  output logic        busy_o,
  output logic        eng_reset_o,
  output logic        eng_go_o,
  output logic [7:0]  eng_i2c_addr_o,
  output logic [3:0]  eng_word_addr_o,
  output logic [7:0]  eng_wdata_o,
  input  logic [7:0]  eng_rdata_i
);

  // One spare slot absorbs the phase offset of the engine's free-running divider.
  localparam logic [SLOT_W-1:0] RUN_WR_LEN = SLOT_W'(WR_SLOTS + 1);
  localparam logic [SLOT_W-1:0] RUN_RD_LEN = SLOT_W'(RD_SLOTS + 1);
  localparam logic [SLOT_W-1:0] TWR_LEN    = SLOT_W'(TWR_SLOTS);

  state_e            state_q, state_d;
  logic              setup_q;
  logic [1:0]        gnt_q;
  logic              prefer_q;
  logic              we_q;
  logic [3:0]        waddr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        rdata_q;

  logic              winner;
  logic              grantNow;
  logic              timerStart;
  logic [SLOT_W-1:0] timerSlots;
  logic              timerExpire;

  assign grantNow = (state_q == ST_IDLE) && (|req_i);
  assign winner   = (req_i == 2'b11) ? prefer_q : req_i[1];

  eeprom_slot_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (timerStart),
    .slots_i  (timerSlots),
    .expire_o (timerExpire)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timerStart = 1'b0;
    timerSlots = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (setup_q) begin
          state_d    = ST_RUN;
          timerStart = 1'b1;
          timerSlots = we_q ? RUN_WR_LEN : RUN_RD_LEN;
        end
      end
      ST_RUN: begin
        if (timerExpire) begin
          if (we_q) begin
            state_d    = ST_TWR;
            timerStart = 1'b1;
            timerSlots = TWR_LEN;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: state_d = ST_DONE;
      ST_TWR: begin
        if (timerExpire) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The engine keeps running through CAPTURE so its read value is still driven when sampled.
  always_comb begin
    busy_o         = 1'b1;
    eng_reset_o    = 1'b1;
    eng_go_o       = 1'b0;
    eng_i2c_addr_o = EE_IDLE;
    done_o         = 2'b00;
    case (state_q)
      ST_IDLE: busy_o = 1'b0;
      ST_SETUP: eng_i2c_addr_o = ctrlByte(we_q);
      ST_RUN, ST_CAPTURE: begin
        eng_reset_o    = 1'b0;
        eng_go_o       = 1'b1;
        eng_i2c_addr_o = ctrlByte(we_q);
      end
      ST_TWR: eng_i2c_addr_o = EE_IDLE;
      ST_DONE: done_o = gnt_q;
      default: busy_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      setup_q  <= 1'b0;
      gnt_q    <= 2'b00;
      prefer_q <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      setup_q <= (state_q == ST_SETUP) ? ~setup_q : 1'b0;
      if (grantNow) begin
        gnt_q    <= winner ? 2'b10 : 2'b01;
        prefer_q <= ~winner;
        we_q     <= req_we_i[winner];
        waddr_q  <= winner ? req_addr_i[7:4] : req_addr_i[3:0];
        wdata_q  <= winner ? req_wdata_i[15:8] : req_wdata_i[7:0];
      end else if (state_q == ST_DONE) begin
        gnt_q <= 2'b00;
      end
      if (state_q == ST_CAPTURE) rdata_q <= eng_rdata_i;
    end
  end

  assign gnt_o           = gnt_q;
  assign rdata_o         = rdata_q;
  assign eng_word_addr_o = waddr_q;
  assign eng_wdata_o     = wdata_q;

endmodule

// File: tb/tb_eeprom_sched.sv
// Directed bench for eeprom_sched, run with shortened slot timing so writes fit a short run.
// Expected DONE positions come from the cycle formulas, evaluated with the bench's own parameters.
module tb_eeprom_sched;

  localparam int TD    = 4;
  localparam int WRS   = 34;
  localparam int RDS   = 44;
  localparam int TWRS  = 6;
  localparam int RD_DONE    = 2 + (RDS + 1) * TD + 1;
  localparam int WR_DONE    = 2 + (WRS + 1) * TD + TWRS * TD;
  localparam int WR_RUN_END = 2 + (WRS + 1) * TD - 1;
  localparam int RD_RUN_END = 2 + (RDS + 1) * TD - 1;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  reqWe;
  logic [7:0]  reqAddr;
  logic [15:0] reqWdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic        busy;
  logic        engReset;
  logic        engGo;
  logic [7:0]  engI2cAddr;
  logic [3:0]  engWordAddr;
  logic [7:0]  engWdata;
  logic [7:0]  engRdata;

  int total;
  int bad;
  int cyc;

  eeprom_sched #(
    .TICK_DIV  (TD),
    .WR_SLOTS  (WRS),
    .RD_SLOTS  (RDS),
    .TWR_SLOTS (TWRS)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .req_i           (req),
    .req_we_i        (reqWe),
    .req_addr_i      (reqAddr),
    .req_wdata_i     (reqWdata),
    .gnt_o           (gnt),
    .done_o          (done),
    .rdata_o         (rdata),
    .busy_o          (busy),
    .eng_reset_o     (engReset),
    .eng_go_o        (engGo),
    .eng_i2c_addr_o  (engI2cAddr),
    .eng_word_addr_o (engWordAddr),
    .eng_wdata_o     (engWdata),
    .eng_rdata_i     (engRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] we,
                               input logic [7:0] addr, input logic [15:0] wd);
    req      = r;
    reqWe    = we;
    reqAddr  = addr;
    reqWdata = wd;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int at);
    while (done === 2'b00 && cyc < limit) step(1);
    at = (done !== 2'b00) ? cyc : -1;
  endtask

  initial begin
    int doneAt;
    int stray;
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 8'h00, 16'h0000);
    engRdata = 8'h00;
    step(3);

    checkOutput("rst_gnt", gnt, 2'b00);
    checkOutput("rst_done", done, 2'b00);
    checkOutput("rst_rdata", rdata, 8'h00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_eng_reset", engReset, 1'b1);
    checkOutput("rst_eng_go", engGo, 1'b0);
    checkOutput("rst_i2c", engI2cAddr, 8'h00);
    checkOutput("rst_waddr", engWordAddr, 4'h0);
    checkOutput("rst_wdata", engWdata, 8'h00);
    reset = 1'b0;
    step(1);

    // Read by requester 0
    engRdata = 8'h3C;
    applyStimulus(2'b01, 2'b00, 8'hF5, 16'h1234);
    step(1);
    cyc = 0;
    checkOutput("rd_gnt", gnt, 2'b01);
    checkOutput("rd_busy", busy, 1'b1);
    checkOutput("rd_setup_reset", engReset, 1'b1);
    checkOutput("rd_setup_i2c", engI2cAddr, 8'hA1);
    applyStimulus(2'b00, 2'b00, 8'h00, 16'h0000);
    stepTo(1);
    checkOutput("rd_setup1_go", engGo, 1'b0);
    stepTo(2);
    checkOutput("rd_run_reset", engReset, 1'b0);
    checkOutput("rd_run_go", engGo, 1'b1);
    checkOutput("rd_run_i2c", engI2cAddr, 8'hA1);
    checkOutput("rd_run_waddr", engWordAddr, 4'h5);
    stepTo(RD_RUN_END);
    checkOutput("rd_runend_go", engGo, 1'b1);
    checkOutput("rd_runend_i2c", engI2cAddr, 8'hA1);
    checkOutput("rd_runend_rdata", rdata, 8'h00);
    waitDone(RD_DONE + 20, doneAt);
    checkOutput("rd_done_cycle", doneAt, RD_DONE);
    checkOutput("rd_done_val", done, 2'b01);
    checkOutput("rd_rdata", rdata, 8'h3C);
    step(1);
    checkOutput("rd_post_gnt", gnt, 2'b00);
    checkOutput("rd_post_busy", busy, 1'b0);
    checkOutput("rd_post_done", done, 2'b00);
    checkOutput("rd_hold_rdata", rdata, 8'h3C);

    // Write by requester 1
    applyStimulus(2'b10, 2'b10, 8'hA3, 16'h9655);
    step(1);
    cyc = 0;
    checkOutput("wr_gnt", gnt, 2'b10);
    checkOutput("wr_i2c", engI2cAddr, 8'hA0);
    checkOutput("wr_wdata", engWdata, 8'h96);
    checkOutput("wr_waddr", engWordAddr, 4'hA);
    applyStimulus(2'b00, 2'b00, 8'h00, 16'h0000);
    stepTo(WR_RUN_END);
    checkOutput("wr_runend_go", engGo, 1'b1);
    checkOutput("wr_runend_i2c", engI2cAddr, 8'hA0);
    step(1);
    checkOutput("wr_twr_i2c", engI2cAddr, 8'h00);
    checkOutput("wr_twr_reset", engReset, 1'b1);
    checkOutput("wr_twr_go", engGo, 1'b0);
    checkOutput("wr_twr_busy", busy, 1'b1);
    waitDone(WR_DONE + 20, doneAt);
    checkOutput("wr_done_cycle", doneAt, WR_DONE);
    checkOutput("wr_done_val", done, 2'b10);
    checkOutput("wr_rdata_kept", rdata, 8'h3C);
    step(2);

    // Both requesting from reset: 01, 10, 01
    doReset();
    engRdata = 8'h5A;
    applyStimulus(2'b11, 2'b00, 8'h21, 16'h0000);
    step(1);
    cyc = 0;
    checkOutput("rr_first_gnt", gnt, 2'b01);
    checkOutput("rr_first_waddr", engWordAddr, 4'h1);
    waitDone(RD_DONE + 20, doneAt);
    checkOutput("rr_first_done", doneAt, RD_DONE);
    step(1);
    checkOutput("rr_gap_gnt", gnt, 2'b00);
    step(1);
    checkOutput("rr_second_gnt", gnt, 2'b10);
    checkOutput("rr_second_waddr", engWordAddr, 4'h2);
    cyc = 0;
    waitDone(RD_DONE + 20, doneAt);
    checkOutput("rr_second_done", doneAt, RD_DONE);
    checkOutput("rr_second_doneval", done, 2'b10);
    step(2);
    checkOutput("rr_third_gnt", gnt, 2'b01);
    applyStimulus(2'b00, 2'b00, 8'h00, 16'h0000);
    cyc = 0;
    waitDone(RD_DONE + 20, doneAt);
    checkOutput("rr_third_done", doneAt, RD_DONE);
    step(2);

    // Inputs change and REQ drops mid-read
    engRdata = 8'hC3;
    applyStimulus(2'b01, 2'b00, 8'h07, 16'h0000);
    step(1);
    cyc = 0;
    stepTo(100);
    applyStimulus(2'b00, 2'b01, 8'hFF, 16'hFFFF);
    step(1);
    checkOutput("drop_waddr", engWordAddr, 4'h7);
    checkOutput("drop_i2c", engI2cAddr, 8'hA1);
    checkOutput("drop_gnt", gnt, 2'b01);
    waitDone(RD_DONE + 20, doneAt);
    checkOutput("drop_done_cycle", doneAt, RD_DONE);
    checkOutput("drop_rdata", rdata, 8'hC3);
    step(2);

    // Reset in the middle of a write
    applyStimulus(2'b01, 2'b01, 8'h0B, 16'h00E7);
    step(1);
    cyc = 0;
    applyStimulus(2'b00, 2'b00, 8'h00, 16'h0000);
    stepTo(100);
    checkOutput("abort_pre_go", engGo, 1'b1);
    reset = 1'b1;
    step(1);
    checkOutput("abort_gnt", gnt, 2'b00);
    checkOutput("abort_eng_reset", engReset, 1'b1);
    checkOutput("abort_eng_go", engGo, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 2'b00);
    checkOutput("abort_i2c", engI2cAddr, 8'h00);
    reset = 1'b0;
    stray = 0;
    repeat (WR_DONE) begin
      if (done !== 2'b00) stray++;
      step(1);
    end
    checkOutput("abort_no_done", stray, 0);
    applyStimulus(2'b01, 2'b00, 8'h04, 16'h0000);
    step(1);
    checkOutput("abort_fresh_gnt", gnt, 2'b01);
    checkOutput("abort_fresh_waddr", engWordAddr, 4'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
